// File: rtl/trivium_keyiv_loader.sv
// ============================================================================
// trivium_keyiv_loader : byte-stream key/IV assembler and warm-up sequencer
//                        that sits in front of the Trivium keystream core.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trivium_keyiv_loader #(
  parameter int KEY_BYTES     = 10,
  parameter int IV_BYTES      = 10,
  parameter int WARMUP_CYCLES = 1152
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    restart,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [8*KEY_BYTES-1:0]  key,
  output logic [8*IV_BYTES-1:0]   iv,
  output logic                    core_load,
  output logic                    core_step,
  output logic                    ks_valid,
  output logic                    busy
);

  localparam int KEY_W     = 8 * KEY_BYTES;
  localparam int IV_W      = 8 * IV_BYTES;
  localparam int MAX_BYTES = (KEY_BYTES > IV_BYTES) ? KEY_BYTES : IV_BYTES;
  localparam int BC_W      = $clog2(MAX_BYTES + 1);
  localparam int WC_W      = $clog2(WARMUP_CYCLES + 1);

  localparam logic [BC_W-1:0] KEY_LAST  = BC_W'(KEY_BYTES - 1);
  localparam logic [BC_W-1:0] IV_LAST   = BC_W'(IV_BYTES - 1);
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD_KEY = 3'd0,
    S_LOAD_IV  = 3'd1,
    S_INIT     = 3'd2,
    S_WARMUP   = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  state_t            state_q,    state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [KEY_W-1:0]  key_q,      key_d;
  logic [IV_W-1:0]   iv_q,       iv_d;

  logic in_load;
  logic xfer;
  logic live;

  assign in_load = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_IV);
  // Ready is also held low while reset is applied so no transfer can be seen then.
  assign byte_ready = rst_n & ena & in_load;
  assign xfer       = byte_valid & byte_ready;
  assign live       = ena & ~restart;

  assign core_load = live & (state_q == S_INIT);
  assign core_step = live & ((state_q == S_WARMUP) || (state_q == S_RUN));
  assign ks_valid  = (state_q == S_RUN);
  assign busy      = (state_q == S_INIT) || (state_q == S_WARMUP);
  assign key       = key_q;
  assign iv        = iv_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    warm_cnt_d = warm_cnt_q;
    key_d      = key_q;
    iv_d       = iv_q;
    if (ena) begin
      if (restart) begin
        // Restart beats any byte offered in the same cycle.
        state_d    = S_LOAD_KEY;
        byte_cnt_d = '0;
        warm_cnt_d = '0;
        key_d      = '0;
        iv_d       = '0;
      end else begin
        case (state_q)
          S_LOAD_KEY: begin
            if (xfer) begin
              key_d = {key_q[KEY_W-9:0], byte_in};
              if (byte_cnt_q == KEY_LAST) begin
                byte_cnt_d = '0;
                state_d    = S_LOAD_IV;
              end else begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
              end
            end
          end
          S_LOAD_IV: begin
            if (xfer) begin
              iv_d = {iv_q[IV_W-9:0], byte_in};
              if (byte_cnt_q == IV_LAST) begin
                byte_cnt_d = '0;
                state_d    = S_INIT;
              end else begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
              end
            end
          end
          S_INIT: begin
            warm_cnt_d = '0;
            state_d    = S_WARMUP;
          end
          S_WARMUP: begin
            if (warm_cnt_q == WARM_LAST) begin
              warm_cnt_d = '0;
              state_d    = S_RUN;
            end else begin
              warm_cnt_d = warm_cnt_q + WC_W'(1);
            end
          end
          S_RUN: begin
            state_d = S_RUN;
          end
          default: begin
            state_d    = S_LOAD_KEY;
            byte_cnt_d = '0;
            warm_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD_KEY;
      byte_cnt_q <= '0;
      warm_cnt_q <= '0;
      key_q      <= '0;
      iv_q       <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trivium_keyiv_loader.sv
// Self-checking bench for trivium_keyiv_loader: queue-based reference model
// plus directed latency/boundary pins and a randomized soak.
`timescale 1ns/1ps
`default_nettype none

module tb_trivium_keyiv_loader;

  localparam int KB = 10;
  localparam int IB = 10;
  localparam int NB = KB + IB;
  localparam int WC = 1152;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [79:0] key;
  logic [79:0] iv;
  logic        core_load;
  logic        core_step;
  logic        ks_valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  trivium_keyiv_loader #(
    .KEY_BYTES(KB), .IV_BYTES(IB), .WARMUP_CYCLES(WC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .restart(restart),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .key(key), .iv(iv), .core_load(core_load), .core_step(core_step),
    .ks_valid(ks_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Bytes accepted since the last restart/reset, whether the load pulse has
  // been issued, and how many core steps have been granted since then.
  logic [7:0] m_bytes[$];
  bit         m_loaded;
  int         m_steps;

  function automatic logic [79:0] pack(input int lo, input int hi);
    logic [79:0] v;
    v = '0;
    for (int i = lo; i < hi; i++)
      if (i < m_bytes.size()) v = {v[71:0], m_bytes[i]};
    return v;
  endfunction

  always @(negedge rst_n) begin
    m_bytes.delete();
    m_loaded = 1'b0;
    m_steps  = 0;
  end

  always @(posedge clk) begin
    if (rst_n && ena) begin
      if (restart) begin
        m_bytes.delete();
        m_loaded = 1'b0;
        m_steps  = 0;
      end else if (m_bytes.size() < NB) begin
        if (byte_valid) m_bytes.push_back(byte_in);
      end else if (!m_loaded) begin
        m_loaded = 1'b1;
      end else begin
        m_steps++;
      end
    end
  end

  always @(negedge clk) begin
    bit full, run, live;
    full = (m_bytes.size() == NB);
    run  = m_loaded && (m_steps >= WC);
    live = rst_n && ena && !restart;
    check("byte_ready", 80'(byte_ready), 80'(rst_n && ena && !full));
    check("core_load",  80'(core_load),  80'(live && full && !m_loaded));
    check("core_step",  80'(core_step),  80'(live && m_loaded));
    check("ks_valid",   80'(ks_valid),   80'(rst_n && run));
    check("busy",       80'(busy),       80'(rst_n && full && !run));
    check("key",        key,             pack(0, KB));
    check("iv",         iv,              pack(KB, NB));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      t++;
      if (t > 200) begin
        timeout_fail("send");
        break;
      end
    end
    tick();
  endtask

  task automatic load20(input bit rnd, input int max_gap);
    logic [7:0] v;
    for (int i = 0; i < NB; i++) begin
      if (rnd) v = 8'($urandom);
      else     v = (i < KB) ? 8'(i + 1) : 8'(8'hA0 + i - KB + 1);
      send(v, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    byte_valid = 1'b0;
  endtask

  // Entered in the cycle right after the last transfer (k = 1).
  task automatic watch_run(input int gap_at, output int k_ks, output int k_load,
                           output int n_load, output int n_step);
    k_ks = 0; k_load = 0; n_load = 0; n_step = 0;
    for (int k = 1; k <= 3000; k++) begin
      ena = !(gap_at > 0 && k >= gap_at && k < gap_at + 5);
      @(negedge clk);
      if (core_load) begin n_load++; k_load = k; end
      if (ks_valid) begin k_ks = k; break; end
      if (core_step) n_step++;
      tick();
    end
    ena = 1'b1;
    if (k_ks == 0) timeout_fail("watch_run");
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_ks, k_load, n_load, n_step, nr, nk;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_key",        key, 80'h0);
    check("rst_iv",         iv, 80'h0);
    check("rst_byte_ready", 80'(byte_ready), 80'h0);
    check("rst_ks_valid",   80'(ks_valid), 80'h0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Known load and warm-up latency.
    load20(1'b0, 0);
    watch_run(0, k_ks, k_load, n_load, n_step);
    check("pin_key",     key, 80'h0102030405060708090A);
    check("pin_iv",      iv,  80'hA1A2A3A4A5A6A7A8A9AA);
    check("pin_n_load",  80'(n_load), 80'd1);
    check("pin_k_load",  80'(k_load), 80'd1);
    check("pin_n_step",  80'(n_step), 80'd1152);
    check("pin_ks_lat",  80'(k_ks),   80'd1154);

    // Bytes offered in RUN are ignored.
    nr = 0; nk = 0;
    repeat (20) begin
      byte_in = 8'hFF; byte_valid = 1'b1;
      @(negedge clk);
      if (byte_ready) nr++;
      if (!ks_valid) nk++;
      tick();
    end
    byte_valid = 1'b0;
    check("run_ready_seen", 80'(nr), 80'd0);
    check("run_ks_drop",    80'(nk), 80'd0);
    check("run_key_held",   key, 80'h0102030405060708090A);
    check("run_iv_held",    iv,  80'hA1A2A3A4A5A6A7A8A9AA);

    // Restart together with the 7th key byte.
    restart = 1'b1; tick(); restart = 1'b0;
    for (int i = 0; i < 6; i++) send(8'($urandom), 0);
    byte_in = 8'h77; byte_valid = 1'b1; restart = 1'b1;
    @(negedge clk);
    check("rst7_ready", 80'(byte_ready), 80'h1);
    tick();
    restart = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check("rst7_key",   key, 80'h0);
    check("rst7_ready_after", 80'(byte_ready), 80'h1);
    tick();

    // Fresh load, then a 5-cycle enable gap at warm-up count 500.
    load20(1'b1, 3);
    watch_run(502, k_ks, k_load, n_load, n_step);
    check("gap_n_step", 80'(n_step), 80'd1152);
    check("gap_ks_lat", 80'(k_ks),   80'd1159);
    check("gap_k_load", 80'(k_load), 80'd1);

    // Asynchronous reset at warm-up count 1000.
    restart = 1'b1; tick(); restart = 1'b0;
    load20(1'b1, 2);
    n_step = 0;
    for (int k = 1; k <= 1001; k++) begin
      @(negedge clk);
      if (core_step) n_step++;
      tick();
    end
    check("pre_rst_steps", 80'(n_step), 80'd1000);
    rst_n = 1'b0;
    #1;
    check("arst_core_step", 80'(core_step), 80'h0);
    check("arst_busy",      80'(busy), 80'h0);
    check("arst_key",       key, 80'h0);
    check("arst_iv",        iv, 80'h0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 80'(byte_ready), 80'h1);
    tick();
    nr = 0;
    repeat (30) begin
      @(negedge clk);
      if (core_step || core_load) nr++;
      tick();
    end
    check("post_rst_quiet", 80'(nr), 80'd0);
    load20(1'b1, 2);
    watch_run(0, k_ks, k_load, n_load, n_step);
    check("reload_ks_lat", 80'(k_ks), 80'd1154);

    // Randomized soak.
    for (int i = 0; i < 6000; i++) begin
      ena        = ($urandom % 10) != 0;
      restart    = ($urandom % 2500) == 0;
      byte_valid = $urandom % 2;
      byte_in    = 8'($urandom);
      tick();
    end
    ena = 1'b1; restart = 1'b0; byte_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
